// File: rtl/kl8_tty.sv
// kl8_tty: PDP-8 console teletype controller bridging the IOT bus to a UART handshake
module kl8_tty #(
  parameter logic [5:0] KBD_DEV = 6'o03,
  parameter logic [5:0] TTY_DEV = 6'o04,
  parameter int TX_GUARD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [5:0]  io_select,
  input  logic [2:0]  io_op,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_clear_ac,
  output logic        io_skip,
  output logic        io_interrupt,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        rx_req,
  input  logic        rx_ack,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data
);
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_GUARD, T_DRAIN} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAPT} rx_state_t;
  localparam logic [3:0] GUARD_LAST = 4'(TX_GUARD - 1);
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [3:0] guard_cnt;
  logic kbd_flag, tpr_flag, tx_pending, shadow_valid;
  logic [7:0] kbuf, tbuf, shadow;
  logic kbd_sel, tty_sel, kcc, tcf, tpc, tpc_shadow, tx_done, rx_capt;
  logic unused_ac_hi;
  assign unused_ac_hi = ^io_data_in[11:8];
  assign kbd_sel = iot && io_select == KBD_DEV;
  assign tty_sel = iot && io_select == TTY_DEV;
  assign kcc = kbd_sel && io_op[1];
  assign tcf = tty_sel && io_op[1];
  assign tpc = tty_sel && io_op[2];
  assign io_skip = (kbd_sel && io_op[0] && kbd_flag) || (tty_sel && io_op[0] && tpr_flag);
  assign io_clear_ac = kcc;
  assign io_data_avail = kbd_sel && io_op[2];
  assign io_data_out = io_data_avail ? {4'b0, kbuf} : 12'b0;
  assign io_interrupt = kbd_flag | tpr_flag;
  assign tx_req = tx_state == T_REQ;
  assign tx_data = tbuf;
  assign rx_req = rx_state == R_REQ;
  assign tx_done = tx_state == T_DRAIN && tx_empty;
  assign rx_capt = rx_state == R_CAPT;
  // A byte that is already committed to go out (in handshake, or starting this edge) must not be disturbed, so a new TPC parks in the shadow
  assign tpc_shadow = tx_state == T_REQ || (tx_state == T_IDLE && tx_pending);
  // Transmit sequencing: request, guard delay, then wait for the line to drain
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  tx_next = tx_pending ? T_REQ : T_IDLE;
      T_REQ:   tx_next = tx_ack ? T_GUARD : T_REQ;
      T_GUARD: tx_next = guard_cnt == GUARD_LAST ? T_DRAIN : T_GUARD;
      default: tx_next = tx_empty ? T_IDLE : T_DRAIN;
    endcase
  end
  // Receive sequencing: fetch only when the keyboard buffer has been consumed
  always_comb begin
    rx_next = R_IDLE;
    case (rx_state)
      R_IDLE:  rx_next = (!rx_empty && !kbd_flag) ? R_REQ : R_IDLE;
      R_REQ:   rx_next = rx_ack ? R_CAPT : R_REQ;
      default: rx_next = R_IDLE;
    endcase
  end
  // State registers and guard counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= T_IDLE;
      rx_state <= R_IDLE;
      guard_cnt <= 4'd0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      guard_cnt <= tx_state == T_GUARD ? guard_cnt + 4'd1 : 4'd0;
    end
  end
  // Flags and buffers; hardware events (capture, drain completion) win over software clears
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      tpr_flag <= 1'b0;
      kbuf <= 8'd0;
      tbuf <= 8'd0;
      shadow <= 8'd0;
      shadow_valid <= 1'b0;
      tx_pending <= 1'b0;
    end else begin
      kbd_flag <= rx_capt || (kbd_flag && !kcc);
      tpr_flag <= tx_done || (tpr_flag && !tcf);
      if (rx_capt) kbuf <= rx_data;
      if (tpc && tpc_shadow) shadow <= io_data_in[7:0];
      shadow_valid <= tpc ? tpc_shadow : shadow_valid && tx_state != T_IDLE;
      tx_pending <= tpc || (tx_pending && tx_state != T_IDLE);
      tbuf <= (tpc && !tpc_shadow) ? io_data_in[7:0] : (tx_state == T_IDLE && shadow_valid) ? shadow : tbuf;
    end
  end
endmodule

// File: doc/kl8_tty.md
Name: kl8_tty

Overview:
- PDP-8 console teletype controller (KL8-style) sitting between the CPU IOT bus and the UART handshake interface (tx_req/tx_ack/tx_empty, rx_req/rx_ack/rx_empty/rx_data).
- Decodes keyboard (device 03) and printer (device 04) IOTs; keeps keyboard and printer flags, keyboard buffer, printer buffer.
- Sequences UART handshakes and raises the interrupt request.

Parameters:
- KBD_DEV, 6'o03, IOT device code for keyboard.
- TTY_DEV, 6'o04, IOT device code for printer.
- TX_GUARD, 1, cycles after tx_ack before tx_empty is sampled (range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- iot  input  1  one-cycle IOT strobe.
- io_select  input  6  device code (MB[3:8]).
- io_op  input  3  IOT pulse bits (MB[9:11]); bit0=P1, bit1=P2, bit2=P4.
- io_data_in  input  12  AC value.
- io_data_out  output  12  data to OR into AC.
- io_data_avail  output  1  io_data_out valid this cycle.
- io_clear_ac  output  1  CPU clears AC before the OR.
- io_skip  output  1  CPU skips next instruction.
- io_interrupt  output  1  interrupt request.
- tx_req  output  1  transmit request.
- tx_ack  input  1  transmit accepted.
- tx_data  output  8  byte to transmit.
- tx_empty  input  1  transmitter idle.
- rx_req  output  1  receive request.
- rx_ack  input  1  receive accepted.
- rx_empty  input  1  no byte available.
- rx_data  input  8  received byte; valid the cycle after rx_ack.

Behaviour:
- Reset values:
  - kbd_flag=0, tpr_flag=0, kbuf=0, tbuf=0, tx_pending=0.
  - Both FSMs idle; tx_req=0, rx_req=0.
  - io_* outputs 0; io_interrupt=0.
- IOT decode is combinational, only while iot=1.
  - Outputs are 0 when iot=0 or io_select matches neither device.
  - Flag and buffer updates take effect at the clock edge that ends the iot cycle.
- Keyboard device:
  - P1 (KSF): io_skip=kbd_flag.
  - P2 (KCC): io_clear_ac=1; clear kbd_flag.
  - P4 (KRS): io_data_out={4'b0,kbuf}; io_data_avail=1.
  - 6036 (KRB): P2 and P4 together.
- Printer device:
  - P1 (TSF): io_skip=tpr_flag.
  - P2 (TCF): clear tpr_flag.
  - P4 (TPC): tbuf<=io_data_in[7:0]; tx_pending<=1.
  - 6046 (TLS): P2 and P4 together.
- io_interrupt = kbd_flag | tpr_flag, registered value.
- TX FSM states: T_IDLE, T_REQ, T_GUARD, T_DRAIN.
  - T_IDLE: if tx_pending, go to T_REQ and clear tx_pending.
  - T_REQ: tx_req=1 and tx_data=tbuf, held until tx_ack is sampled high, then go to T_GUARD.
  - T_GUARD: wait TX_GUARD cycles, then go to T_DRAIN.
  - T_DRAIN: when tx_empty=1, set tpr_flag and go to T_IDLE.
  - tx_data tracks tbuf at all times.
  - tbuf must not change while in T_REQ. A TPC arriving then is held in a one-entry shadow with tx_pending and copied to tbuf on return to T_IDLE.
  - TPC in T_GUARD or T_DRAIN writes tbuf and sets tx_pending. The byte is sent after the current one completes.
  - A second TPC before the first pending byte starts overwrites the pending byte (last write wins).
- RX FSM states: R_IDLE, R_REQ, R_CAPT.
  - R_IDLE: if rx_empty=0 and kbd_flag=0, go to R_REQ.
  - R_REQ: rx_req=1 until rx_ack is sampled high, then go to R_CAPT with rx_req=0.
  - R_CAPT: kbuf<=rx_data; kbd_flag<=1; go to R_IDLE.
  - No fetch while kbd_flag=1, so kbuf is never overwritten unread.
- Simultaneous events:
  - KCC/KRB on the same edge as R_CAPT: capture wins, kbd_flag=1, kbuf=new byte. io_data_out that cycle shows the old kbuf.
  - TCF/TLS on the same edge as the T_DRAIN completion: completion wins, tpr_flag=1.
- Reset mid-transfer aborts both FSMs immediately. tx_req and rx_req are 0 in the cycle after reset; a pending byte is lost.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; no IOT gives a skip; io_interrupt=0.
- rx_empty=0, rx_data=8'o301 one cycle after rx_ack -> rx_req high until ack; then kbd_flag=1 and io_interrupt=1. KSF (6031) -> io_skip=1. KRB (6036) -> io_clear_ac=1, io_data_out=12'o0301, io_data_avail=1; kbd_flag=0 next cycle.
- TLS (6046) with AC=12'o0215; uart acks after 2 cycles and holds tx_empty=0 for 20 cycles -> tx_data=8'o215 while tx_req high. tpr_flag=0 until tx_empty returns to 1, then tpr_flag=1. TSF -> io_skip=1.
- TPC 12'o0101 then TPC 12'o0102 while the first is in T_DRAIN -> bytes 0101 then 0102 transmitted in order, each with its own req/ack.
- Two bytes queued (rx_empty=0 throughout); first flag never cleared -> only one rx_req handshake. After KCC, second handshake occurs and kbuf=second byte.
- Assert reset while in T_REQ and in R_REQ -> tx_req=0 and rx_req=0 next cycle; flags=0; no further handshakes without new stimulus.
